// File: rtl/baccarat_round_ctrl.sv
// Batch sequencer above the baccarat game FSM: resets, paces, scores and tallies ROUNDS games.
// Optional macro STREAK_TRACK_EN adds best_streak/best_side (longest same-side win run).
module baccarat_round_ctrl #(
    parameter int unsigned ROUNDS      = 8,
    parameter int unsigned STEP_DIV    = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned MAX_STEPS   = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             slow_clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             player_win_light,
    input  logic             dealer_win_light,
    output logic             game_resetb,
    output logic             game_step,
    output logic [CNT_W-1:0] round_count,
    output logic [CNT_W-1:0] pwins,
    output logic [CNT_W-1:0] dwins,
    output logic [CNT_W-1:0] ties,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
`ifdef STREAK_TRACK_EN
    ,
    output logic [CNT_W-1:0] best_streak,
    output logic             best_side
`endif
);

    localparam int unsigned DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_PLAY  = 3'd2,
        S_HOLD  = 3'd3,
        S_TALLY = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OUT_NONE = 2'd0,
        OUT_P    = 2'd1,
        OUT_D    = 2'd2,
        OUT_T    = 2'd3
    } outcome_e;

    state_e              state, state_nxt;
    outcome_e            outcome, outcome_nxt;
    logic [DIV_W-1:0]    div_cnt, div_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [STEP_W-1:0]   step_cnt, step_nxt;
    logic [CNT_W-1:0]    round_nxt, pwins_nxt, dwins_nxt, ties_nxt;
    logic                timeout_nxt, game_resetb_nxt, game_step_nxt, busy_nxt, done_nxt;
`ifdef STREAK_TRACK_EN
    logic [CNT_W-1:0]    cur_streak, cur_streak_nxt, best_streak_nxt;
    logic                cur_side, cur_side_nxt, best_side_nxt, win_side;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Next-state, next-counter and next-output decode; outputs are registered from these.
    always_comb begin
        state_nxt   = state;
        outcome_nxt = outcome;
        div_nxt     = div_cnt;
        hold_nxt    = hold_cnt;
        step_nxt    = step_cnt;
        round_nxt   = round_count;
        pwins_nxt   = pwins;
        dwins_nxt   = dwins;
        ties_nxt    = ties;
        timeout_nxt = timeout_err;
`ifdef STREAK_TRACK_EN
        cur_streak_nxt  = cur_streak;
        cur_side_nxt    = cur_side;
        best_streak_nxt = best_streak;
        best_side_nxt   = best_side;
        win_side        = (outcome == OUT_P);
`endif
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nxt   = S_CLR;
                        round_nxt   = '0;
                        pwins_nxt   = '0;
                        dwins_nxt   = '0;
                        ties_nxt    = '0;
                        timeout_nxt = 1'b0;
`ifdef STREAK_TRACK_EN
                        cur_streak_nxt  = '0;
                        cur_side_nxt    = 1'b0;
                        best_streak_nxt = '0;
                        best_side_nxt   = 1'b0;
`endif
                    end
                end
                S_CLR: begin
                    state_nxt = S_PLAY;
                    div_nxt   = '0;
                    step_nxt  = '0;
                end
                S_PLAY: begin
                    step_nxt = step_cnt + STEP_W'(game_step);
                    div_nxt  = (div_cnt == DIV_W'(STEP_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
                    // A showing outcome beats the step limit in the same cycle.
                    if (player_win_light || dealer_win_light) begin
                        state_nxt = S_HOLD;
                        hold_nxt  = '0;
                        if (player_win_light && dealer_win_light) outcome_nxt = OUT_T;
                        else if (player_win_light)                outcome_nxt = OUT_P;
                        else                                      outcome_nxt = OUT_D;
                    end else if (step_cnt == STEP_W'(MAX_STEPS)) begin
                        state_nxt   = S_IDLE;
                        timeout_nxt = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) state_nxt = S_TALLY;
                    else                                      hold_nxt  = hold_cnt + HOLD_W'(1);
                end
                S_TALLY: begin
                    unique case (outcome)
                        OUT_P:   pwins_nxt = sat_inc(pwins);
                        OUT_D:   dwins_nxt = sat_inc(dwins);
                        OUT_T:   ties_nxt  = sat_inc(ties);
                        default: ;
                    endcase
`ifdef STREAK_TRACK_EN
                    // A tie breaks the run; equal-length runs keep the earlier side.
                    if (outcome == OUT_T) begin
                        cur_streak_nxt = '0;
                    end else begin
                        if (cur_streak != '0 && cur_side == win_side) cur_streak_nxt = sat_inc(cur_streak);
                        else                                           cur_streak_nxt = CNT_W'(1);
                        cur_side_nxt = win_side;
                        if (cur_streak_nxt > best_streak) begin
                            best_streak_nxt = cur_streak_nxt;
                            best_side_nxt   = win_side;
                        end
                    end
`endif
                    round_nxt = round_count + CNT_W'(1);
                    state_nxt = (round_nxt == CNT_W'(ROUNDS)) ? S_DONE : S_CLR;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        game_resetb_nxt = !(state_nxt == S_IDLE || state_nxt == S_CLR);
        game_step_nxt   = (state_nxt == S_CLR) ||
                          (state_nxt == S_PLAY && div_nxt == DIV_W'(STEP_DIV - 1) &&
                           step_nxt < STEP_W'(MAX_STEPS));
        busy_nxt        = (state_nxt == S_CLR) || (state_nxt == S_PLAY) ||
                          (state_nxt == S_HOLD) || (state_nxt == S_TALLY);
        done_nxt        = (state_nxt == S_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state       <= S_IDLE;
            outcome     <= OUT_NONE;
            div_cnt     <= '0;
            hold_cnt    <= '0;
            step_cnt    <= '0;
            round_count <= '0;
            pwins       <= '0;
            dwins       <= '0;
            ties        <= '0;
            timeout_err <= 1'b0;
            game_resetb <= 1'b0;
            game_step   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef STREAK_TRACK_EN
            cur_streak  <= '0;
            cur_side    <= 1'b0;
            best_streak <= '0;
            best_side   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            outcome     <= outcome_nxt;
            div_cnt     <= div_nxt;
            hold_cnt    <= hold_nxt;
            step_cnt    <= step_nxt;
            round_count <= round_nxt;
            pwins       <= pwins_nxt;
            dwins       <= dwins_nxt;
            ties        <= ties_nxt;
            timeout_err <= timeout_nxt;
            game_resetb <= game_resetb_nxt;
            game_step   <= game_step_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
`ifdef STREAK_TRACK_EN
            cur_streak  <= cur_streak_nxt;
            cur_side    <= cur_side_nxt;
            best_streak <= best_streak_nxt;
            best_side   <= best_side_nxt;
`endif
        end
    end

endmodule
